// File: rtl/icache_ctrl.sv
// icache_ctrl -- direct-mapped instruction cache controller.
//
// Lookup is combinational and zero-latency in IDLE.
// A miss walks IDLE -> REQ -> REFILL -> IDLE:
//   - REQ holds the refill request until memory acknowledges it.
//   - REFILL collects BEATS 32-bit beats and then installs the line.
//
// Optional feature: define ICACHE_STATS_EN to enable the hit/miss counters.
// Without it, both counter outputs are tied to zero.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   core2icache_addr        fetch address (bits [3:0] ignored)
//   icache2core_data        128-bit line, word i at [32i+31:32i]
//   icache2core_data_valid  data valid for the presented address this cycle
//   flush                   invalidate every line (fence.i)
//   icache2mem_req/_addr    refill request and line-aligned refill address
//   mem2icache_ack          memory accepted the request
//   mem2icache_data/_valid  refill beat and its strobe
//   hit_count, miss_count   statistics counters
module icache_ctrl #(
  parameter int LINES = 64,
  parameter int BEATS = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  core2icache_addr,
  output logic [127:0] icache2core_data,
  output logic         icache2core_data_valid,
  input  logic         flush,
  output logic         icache2mem_req,
  output logic [31:0]  icache2mem_addr,
  input  logic         mem2icache_ack,
  input  logic [31:0]  mem2icache_data,
  input  logic         mem2icache_data_valid,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 28 - IDXW;
  localparam int BW   = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, REFILL} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             miss_addr_q, miss_addr_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic                    flush_seen_q, flush_seen_d;

  logic [LINES-1:0]        valid_q;
  logic [TAGW-1:0]         tag_q  [LINES];
  logic [127:0]            data_q [LINES];
  // Holds the first BEATS-1 beats; the last beat goes straight into the array.
  logic [32*(BEATS-1)-1:0] buf_q;

  logic [IDXW-1:0]         idx, miss_idx;
  logic [TAGW-1:0]         tag, miss_tag;
  logic                    hit, launch, fill;

  logic unused_addr_bits;
  assign unused_addr_bits = ^core2icache_addr[3:0];

  assign idx      = core2icache_addr[4 +: IDXW];
  assign tag      = core2icache_addr[31 -: TAGW];
  assign miss_idx = miss_addr_q[4 +: IDXW];
  assign miss_tag = miss_addr_q[31 -: TAGW];

  // Lookup is only meaningful in IDLE.
  // During a miss the arrays belong to the refill.
  assign hit = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);
  assign icache2core_data_valid = hit && !flush;
  assign icache2core_data       = data_q[idx];
  assign icache2mem_addr        = miss_addr_q;

  always_comb begin
    state_d        = state_q;
    miss_addr_d    = miss_addr_q;
    beat_d         = beat_q;
    flush_seen_d   = flush_seen_q | flush;
    icache2mem_req = 1'b0;
    launch         = 1'b0;
    fill           = 1'b0;
    case (state_q)
      IDLE: begin
        beat_d       = '0;
        flush_seen_d = 1'b0;
        if (!flush && !hit) begin
          state_d     = REQ;
          miss_addr_d = {core2icache_addr[31:4], 4'b0000};
          launch      = 1'b1;
        end
      end
      REQ: begin
        icache2mem_req = 1'b1;
        if (mem2icache_ack) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem2icache_data_valid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            fill    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      beat_q       <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      beat_q       <= beat_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  // A flush clears every line.
  // A line completing in a miss that saw a flush is installed invalid,
  // so stale instructions fetched before the fence are never served.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= '0;
      end
      if (fill) begin
        valid_q[miss_idx] <= !flush_seen_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == REFILL && mem2icache_data_valid && beat_q != LAST_BEAT) begin
      for (int k = 0; k < BEATS - 1; k++) begin
        if (beat_q == BW'(k)) begin
          buf_q[k*32 +: 32] <= mem2icache_data;
        end
      end
    end
    if (fill) begin
      data_q[miss_idx] <= {mem2icache_data, buf_q};
      tag_q[miss_idx]  <= miss_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (icache2core_data_valid) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (launch) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_launch;
  assign unused_launch = launch;
  assign hit_count     = '0;
  assign miss_count    = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;
  localparam int LINES = 64;

`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  core_addr;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         flush_s;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_data;
  logic         mem_dv;
  logic [31:0]  hit_count, miss_count;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] L0 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L1 = 128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4;
  localparam logic [127:0] L2 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] L3 = 128'hCAFEF00D_DEADBEEF_0BADC0DE_FEEDFACE;
  localparam logic [127:0] L4 = 128'h30303030_31313131_32323232_33333333;
  localparam logic [127:0] L5 = 128'h55550000_55551111_55552222_55553333;

  always #5 clock = ~clock;

  icache_ctrl #(.LINES(LINES), .BEATS(4)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .core2icache_addr      (core_addr),
    .icache2core_data      (rd_data),
    .icache2core_data_valid(rd_valid),
    .flush                 (flush_s),
    .icache2mem_req        (mem_req),
    .icache2mem_addr       (mem_addr),
    .mem2icache_ack        (mem_ack),
    .mem2icache_data       (mem_data),
    .mem2icache_data_valid (mem_dv),
    .hit_count             (hit_count),
    .miss_count            (miss_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic f, input logic ak,
                       input logic v, input logic [31:0] d);
    core_addr = a;
    flush_s   = f;
    mem_ack   = ak;
    mem_dv    = v;
    mem_data  = d;
    #1;
  endtask

  // Called in the cycle after a miss was launched.
  // Waits (bounded) for the request, acks it, then delivers the four beats.
  // Returns in the first IDLE cycle, with the address re-presented.
  task automatic finish_refill(input logic [31:0] a, input logic [127:0] line);
    int n;
    n = 0;
    drive(a, 1'b0, 1'b0, 1'b0, 32'h0);
    while (!mem_req && n < 8) begin
      tick();
      drive(a, 1'b0, 1'b0, 1'b0, 32'h0);
      n++;
    end
    drive(a, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(a, 1'b0, 1'b0, 1'b1, line[32*k +: 32]);
      tick();
    end
    drive(a, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic fill_line(input logic [31:0] a, input logic [127:0] line);
    drive(a, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    finish_refill(a, line);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
    tick();
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    checks++; if (hit_count !== 32'h0) begin errors++; $display("FAIL reset_hits: got %0d want 0", hit_count); end
    checks++; if (miss_count !== 32'h0) begin errors++; $display("FAIL reset_misses: got %0d want 0", miss_count); end
    reset = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_first_dv: got %b want 0", rd_valid); end
  endtask

  task automatic test_cold_miss();
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL cold_req: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL cold_addr: got %h want 0", mem_addr); end
    finish_refill(32'h0, L0);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL cold_dv: got %b want 1", rd_valid); end
    checks++; if (rd_data !== L0) begin errors++; $display("FAIL cold_data: got %h want %h", rd_data, L0); end
    tick();
  endtask

  task automatic test_hit();
    drive(32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL hit_dv: got %b want 1", rd_valid); end
    checks++; if (rd_data !== L0) begin errors++; $display("FAIL hit_data: got %h want %h", rd_data, L0); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL hit_req: got %b want 0", mem_req); end
    tick();
    checks++; if (hit_count !== (STATS ? 32'd2 : 32'd0)) begin errors++; $display("FAIL stats_hits: got %0d want %0d", hit_count, STATS ? 2 : 0); end
    checks++; if (miss_count !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL stats_misses: got %0d want %0d", miss_count, STATS ? 1 : 0); end
  endtask

  task automatic test_conflict();
    fill_line(32'h400, L1);
    checks++; if (rd_valid !== 1'b1 || rd_data !== L1) begin errors++; $display("FAIL conflict_fill: dv=%b data=%h want 1/%h", rd_valid, rd_data, L1); end
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL conflict_evicted: got %b want 0", rd_valid); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL conflict_req: req=%b addr=%h want 1/0", mem_req, mem_addr); end
    finish_refill(32'h0, L0);
  endtask

  task automatic test_addr_change();
    drive(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL req_state_dv: got %b want 0", rd_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL chg_req: req=%b addr=%h want 1/100", mem_req, mem_addr); end
    drive(32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(32'h200, 1'b0, 1'b0, 1'b1, L2[32*k +: 32]);
      if (k == 0) begin
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL refill_state_dv: got %b want 0", rd_valid); end
      end
      tick();
    end
    drive(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (rd_valid !== 1'b1 || rd_data !== L2) begin errors++; $display("FAIL chg_fill: dv=%b data=%h want 1/%h", rd_valid, rd_data, L2); end
    drive(32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL chg_new_dv: got %b want 0", rd_valid); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL chg_new_req: req=%b addr=%h want 1/200", mem_req, mem_addr); end
    finish_refill(32'h200, L3);
  endtask

  task automatic test_flush();
    drive(32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(32'h300, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(32'h300, (k == 1), 1'b0, 1'b1, L4[32*k +: 32]);
      tick();
    end
    drive(32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush_refill_dv: got %b want 0", rd_valid); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin errors++; $display("FAIL flush_refill_req: req=%b addr=%h want 1/300", mem_req, mem_addr); end
    finish_refill(32'h300, L4);
    checks++; if (rd_valid !== 1'b1 || rd_data !== L4) begin errors++; $display("FAIL flush_refetch: dv=%b data=%h want 1/%h", rd_valid, rd_data, L4); end
    drive(32'h300, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_dv: got %b want 0", rd_valid); end
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL flush_no_miss: got %b want 0", mem_req); end
    drive(32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush_after_dv: got %b want 0", rd_valid); end
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL flush_after_req: got %b want 1", mem_req); end
    finish_refill(32'h300, L4);
  endtask

  task automatic test_reset_midrefill();
    drive(32'h500, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(32'h500, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(32'h500, 1'b0, 1'b0, 1'b1, 32'hEEEE0000 + k);
      tick();
    end
    reset = 1'b1;
    drive(32'h500, 1'b0, 1'b0, 1'b1, 32'hEEEE0002);
    tick();
    reset = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midreset_req: got %b want 0", mem_req); end
    drive(32'h500, 1'b0, 1'b0, 1'b1, 32'hEEEE0003);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midreset_dv: got %b want 0", rd_valid); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin errors++; $display("FAIL midreset_req2: req=%b addr=%h want 1/500", mem_req, mem_addr); end
    drive(32'h500, 1'b0, 1'b0, 1'b1, 32'hBAD0BAD0);
    tick();
    finish_refill(32'h500, L5);
    checks++; if (rd_valid !== 1'b1 || rd_data !== L5) begin errors++; $display("FAIL midreset_fill: dv=%b data=%h want 1/%h", rd_valid, rd_data, L5); end
  endtask

  // Reference model: cache contents per index plus the phase of the miss.
  task automatic test_random();
    logic         mvalid [LINES];
    logic [31:0]  mla    [LINES];
    logic [127:0] mdat   [LINES];
    logic [31:0]  a, d, mline;
    logic [127:0] acc;
    logic         f, ak, v;
    bit           exp_dv, fseen, fill;
    int           ph, wt, k, ix, hits, misses;
    ph = 0; wt = 0; k = 0; hits = 0; misses = 0;
    fseen = 1'b0; mline = '0; acc = '0;
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < LINES; i++) begin
      mvalid[i] = 1'b0; mla[i] = '0; mdat[i] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = ($urandom_range(0, 2) << 10) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
      f  = ($urandom_range(0, 24) == 0);
      d  = $urandom;
      ix = int'(a[9:4]);
      fill = 1'b0;
      exp_dv = 1'b0;
      if (ph == 0) begin
        ak = ($urandom_range(0, 3) == 0);
        v  = ($urandom_range(0, 3) == 0);
      end else if (ph == 1) begin
        ak = (wt == 0);
        v  = ($urandom_range(0, 2) == 0);
      end else begin
        ak = ($urandom_range(0, 3) == 0);
        v  = ($urandom_range(0, 1) == 1);
      end
      drive(a, f, ak, v, d);
      if (ph == 0) begin
        exp_dv = mvalid[ix] && (mla[ix][31:10] == a[31:10]) && !f;
        checks++; if (rd_valid !== exp_dv) begin errors++; $display("FAIL rnd_dv: cyc %0d addr %h got %b want %b", c, a, rd_valid, exp_dv); end
        if (exp_dv) begin
          hits++;
          checks++; if (rd_data !== mdat[ix]) begin errors++; $display("FAIL rnd_data: cyc %0d got %h want %h", c, rd_data, mdat[ix]); end
        end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rnd_idle_req: cyc %0d got %b want 0", c, mem_req); end
      end else if (ph == 1) begin
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rnd_req_dv: cyc %0d got %b want 0", c, rd_valid); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== mline) begin errors++; $display("FAIL rnd_req: cyc %0d req=%b addr=%h want 1/%h", c, mem_req, mem_addr, mline); end
      end else begin
        checks++; if (rd_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rnd_refill: cyc %0d dv=%b req=%b want 0/0", c, rd_valid, mem_req); end
      end
      if (ph == 0) begin
        if (!exp_dv && !f) begin
          ph = 1; mline = {a[31:4], 4'h0}; fseen = 1'b0; wt = $urandom_range(0, 3); misses++;
        end
      end else if (ph == 1) begin
        fseen = fseen | f;
        if (wt == 0) begin ph = 2; k = 0; end
        else wt--;
      end else begin
        fseen = fseen | f;
        if (v) begin
          acc[32*k +: 32] = d;
          k++;
          if (k == 4) fill = 1'b1;
        end
      end
      if (f) begin
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
      end
      if (fill) begin
        mvalid[mline[9:4]] = !fseen;
        mla[mline[9:4]]    = mline;
        mdat[mline[9:4]]   = acc;
        ph = 0;
      end
      tick();
    end
    checks++; if (hit_count !== (STATS ? 32'(hits) : 32'd0)) begin errors++; $display("FAIL rnd_hits: got %0d want %0d", hit_count, STATS ? hits : 0); end
    checks++; if (miss_count !== (STATS ? 32'(misses) : 32'd0)) begin errors++; $display("FAIL rnd_misses: got %0d want %0d", miss_count, STATS ? misses : 0); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_addr_change();
    test_flush();
    test_reset_midrefill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
